i2c_adc_target: RTL



---
 rtl/i2c_adc_target.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_adc_target.sv
// I2C target (7-bit address ADDR) exposing an ADS1115-style register map:
// pointer 00 = conversion (RO), 01 = config (RW), 10/11 = read as zero.
// Latency: SYNC_STAGES+1 clk from a pin edge to the registered response on sda.
// Backpressure: none; SCL is input only and the target never stretches the clock.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   scl, sda      I2C bus (sda open-drain: driven to 0 or released to z)
//   sample_in     conversion result, loaded when sample_valid is high
//   config_out    current config register
//   config_wr     1-clk pulse when a complete config byte pair commits
//   busy          high from address-matched ACK until STOP / NACK / other address
//
// Optional feature (macro I2C_TGT_ALERT_RDY_EN): output alert_rdy_n, cleared the
// clk after sample_valid, set again when a conversion MSB byte has been sent.

module i2c_adc_target #(
    parameter logic [6:0]  ADDR         = 7'h48,
    parameter logic [15:0] CONFIG_RESET = 16'h8583,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] config_out,
    output logic        config_wr,
    output logic        busy
`ifdef I2C_TGT_ALERT_RDY_EN
    ,
    output logic        alert_rdy_n
`endif
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PTR,
        S_WR_MSB,
        S_WR_LSB,
        S_RD_MSB,
        S_RD_LSB,
        S_WAIT
    } state_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Input synchronizers and bus event detection
    // ------------------------------------------------------------------
    logic [SS-1:0] scl_sync, sda_sync;
    logic          scl_q, sda_q;
    logic          scl_s, sda_s;
    logic          scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SS-2:0], scl};
            sda_sync <= {sda_sync[SS-2:0], sda};
            scl_q    <= scl_sync[SS-1];
            sda_q    <= sda_sync[SS-1];
        end
    end

    assign scl_s     = scl_sync[SS-1];
    assign sda_s     = sda_sync[SS-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    // ------------------------------------------------------------------
    // Byte framing state
    // ------------------------------------------------------------------
    logic [2:0]  bit_cnt;     // index of the next bit to be clocked
    logic        got_byte;    // all 8 data bits seen, waiting for the falling edge
    logic        ack_phase;   // inside the 9th (ACK) bit
    logic [7:0]  rx_shift;
    logic        m_ack;       // master ACK sampled during a read
    logic        sda_oe;
    logic [1:0]  pointer;
    logic [7:0]  wr_hi;
    logic [15:0] conv_reg;
    logic [15:0] config_reg;
    logic [15:0] tx_shift;
    logic [15:0] reg_sel;

    logic is_rx, is_tx, byte_end, ack_end, addr_match, tx_bit;

    assign is_rx      = (state == S_ADDR) || (state == S_PTR) ||
                        (state == S_WR_MSB) || (state == S_WR_LSB);
    assign is_tx      = (state == S_RD_MSB) || (state == S_RD_LSB);
    // falling edge after bit 0: start of the ACK bit
    assign byte_end   = scl_fall & got_byte & ~ack_phase;
    // falling edge that closes the ACK bit
    assign ack_end    = scl_fall & ack_phase;
    assign addr_match = (rx_shift[7:1] == ADDR);
    assign tx_bit     = tx_shift[{(state == S_RD_MSB), bit_cnt}];

    assign sda        = sda_oe ? 1'b0 : 1'bz;
    assign config_out = config_reg;

    always_comb begin
        reg_sel = 16'h0000;
        case (pointer)
            2'b00:   reg_sel = conv_reg;
            2'b01:   reg_sel = config_reg;
            default: reg_sel = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (stop_det) begin
            state_nx = S_IDLE;
        end else if (start_det) begin
            state_nx = S_ADDR;
        end else begin
            case (state)
                S_ADDR: begin
                    if (byte_end && !addr_match) state_nx = S_IDLE;
                    else if (ack_end)            state_nx = rx_shift[0] ? S_RD_MSB : S_PTR;
                end
                S_PTR:    if (ack_end) state_nx = S_WR_MSB;
                S_WR_MSB: if (ack_end) state_nx = S_WR_LSB;
                S_WR_LSB: if (ack_end) state_nx = S_WR_MSB;
                S_RD_MSB: if (ack_end) state_nx = m_ack ? S_RD_LSB : S_WAIT;
                S_RD_LSB: if (ack_end) state_nx = m_ack ? S_RD_MSB : S_WAIT;
                default:  state_nx = state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 3'd7;
            got_byte   <= 1'b0;
            ack_phase  <= 1'b0;
            rx_shift   <= 8'h00;
            m_ack      <= 1'b0;
            sda_oe     <= 1'b0;
            pointer    <= 2'b00;
            wr_hi      <= 8'h00;
            conv_reg   <= 16'h0000;
            config_reg <= CONFIG_RESET;
            tx_shift   <= 16'h0000;
            config_wr  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            config_wr <= 1'b0;
            if (sample_valid) conv_reg <= sample_in;

            if (stop_det || start_det) begin
                // any bus condition aborts the byte in flight
                bit_cnt   <= 3'd7;
                got_byte  <= 1'b0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                if (stop_det) busy <= 1'b0;
            end else if (is_rx) begin
                if (scl_rise && !ack_phase && !got_byte) begin
                    rx_shift <= {rx_shift[6:0], sda_s};
                    if (bit_cnt == 3'd0) got_byte <= 1'b1;
                    else                 bit_cnt  <= bit_cnt - 3'd1;
                end
                if (byte_end) begin
                    got_byte <= 1'b0;
                    if (state == S_ADDR && !addr_match) begin
                        busy <= 1'b0;       // not for us: leave sda released
                    end else begin
                        ack_phase <= 1'b1;
                        sda_oe    <= 1'b1;
                        case (state)
                            S_ADDR: begin
                                busy <= 1'b1;
                                if (rx_shift[0]) tx_shift <= reg_sel;
                            end
                            S_PTR:    pointer <= rx_shift[1:0];
                            S_WR_MSB: wr_hi   <= rx_shift;
                            default:  ;
                        endcase
                    end
                end
                if (ack_end) begin
                    ack_phase <= 1'b0;
                    bit_cnt   <= 3'd7;
                    sda_oe    <= 1'b0;
                    if (state == S_WR_LSB && pointer == 2'b01) begin
                        config_reg <= {wr_hi, rx_shift};
                        config_wr  <= 1'b1;
                    end
                    // read address: present the first data bit right away
                    if (state == S_ADDR && rx_shift[0]) sda_oe <= ~tx_shift[15];
                end
            end else if (is_tx) begin
                if (scl_rise && !ack_phase && !got_byte) begin
                    if (bit_cnt == 3'd0) got_byte <= 1'b1;
                    else                 bit_cnt  <= bit_cnt - 3'd1;
                end
                if (scl_rise && ack_phase) m_ack <= ~sda_s;
                if (byte_end) begin
                    got_byte  <= 1'b0;
                    ack_phase <= 1'b1;
                    sda_oe    <= 1'b0;       // master owns the 9th bit
                end else if (scl_fall && !ack_phase) begin
                    sda_oe <= ~tx_bit;
                end
                if (ack_end) begin
                    ack_phase <= 1'b0;
                    bit_cnt   <= 3'd7;
                    if (m_ack) begin
                        if (state == S_RD_MSB) begin
                            sda_oe <= ~tx_shift[7];
                        end else begin
                            // fresh coherent snapshot for the next 16-bit word
                            tx_shift <= reg_sel;
                            sda_oe   <= ~reg_sel[15];
                        end
                    end else begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef I2C_TGT_ALERT_RDY_EN
    logic alert_clr;
    assign alert_clr = (state == S_RD_MSB) && byte_end && (pointer == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               alert_rdy_n <= 1'b1;
        else if (sample_valid) alert_rdy_n <= 1'b0;
        else if (alert_clr)    alert_rdy_n <= 1'b1;
    end
`endif

endmodule
